// File: rtl/ball_controller_if.sv
// Signal bundle between the video/game logic and the ball controller.
// The master side drives timing and control; the slave side returns position and score events.
interface ball_controller_if;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        launch;
   logic [7:0]  vel_x;
   logic [7:0]  vel_y;
   logic        bounce_x;
   logic        pause;
   logic [15:0] x;
   logic [15:0] y;
   logic [1:0]  ball_state;
   logic        score_l;
   logic        score_r;

   modport master (
      output hcount, vcount, launch, vel_x, vel_y, bounce_x, pause,
      input  x, y, ball_state, score_l, score_r
   );

   modport slave (
      input  hcount, vcount, launch, vel_x, vel_y, bounce_x, pause,
      output x, y, ball_state, score_l, score_r
   );
endinterface

// File: rtl/ball_controller.sv
// Pong ball motion controller: once-per-frame position update, wall bounces,
// paddle reversal, scoring and a timed respawn.
module ball_controller #(
   parameter int SCREEN_W    = 1024,
   parameter int SCREEN_H    = 768,
   parameter int BALL_SIZE   = 64,
   parameter int X0          = 480,
   parameter int Y0          = 352,
   parameter int HIDE_FRAMES = 60
) (
   input  logic             clk,
   input  logic             reset,
   ball_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      SCORED = 2'd2
   } state_t;

   localparam int                CW       = (HIDE_FRAMES > 1) ? $clog2(HIDE_FRAMES) : 1;
   localparam logic signed [16:0] X_MAX   = 17'(SCREEN_W - BALL_SIZE);
   localparam logic signed [16:0] Y_MAX   = 17'(SCREEN_H - BALL_SIZE);
   localparam logic [15:0]        X_INIT  = 16'(X0);
   localparam logic [15:0]        Y_INIT  = 16'(Y0);
   localparam logic [CW-1:0]      CNT_END = CW'(HIDE_FRAMES - 1);

   // Two's-complement negate; -128 has no positive twin so it clamps to +127.
   function automatic logic [7:0] neg_sat(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h80) begin
         r = 8'h7F;
      end else begin
         r = (~v) + 8'd1;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [7:0]  vx_q, vx_d;
   logic [7:0]  vy_q, vy_d;
   logic        pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        score_l_q, score_l_d;
   logic        score_r_q, score_r_d;
   logic [1:0]  ball_state_q, ball_state_d;

   logic               frame_tick_s;
   logic               step_s;
   logic [7:0]         vx_eff_s;
   logic signed [16:0] nx_s;
   logic signed [16:0] ny_s;
   logic               exit_l_s;
   logic               exit_r_s;

   assign frame_tick_s = (bus.hcount == 11'd0) && (bus.vcount == 10'(SCREEN_H));
   assign step_s       = (state_q == MOVING) && frame_tick_s && !bus.pause;
   // A bounce arriving on the tick itself is folded in with any earlier pending one.
   assign vx_eff_s     = (pend_q || bus.bounce_x) ? neg_sat(vx_q) : vx_q;
   assign nx_s         = $signed({1'b0, x_q}) + $signed({{9{vx_eff_s[7]}}, vx_eff_s});
   assign ny_s         = $signed({1'b0, y_q}) + $signed({{9{vy_q[7]}}, vy_q});
   assign exit_r_s     = (nx_s < 17'sd0);
   assign exit_l_s     = (nx_s > X_MAX);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         x_q          <= X_INIT;
         y_q          <= Y_INIT;
         vx_q         <= 8'd0;
         vy_q         <= 8'd0;
         pend_q       <= 1'b0;
         cnt_q        <= '0;
         score_l_q    <= 1'b0;
         score_r_q    <= 1'b0;
         ball_state_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         vx_q         <= vx_d;
         vy_q         <= vy_d;
         pend_q       <= pend_d;
         cnt_q        <= cnt_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         ball_state_q <= ball_state_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.launch) state_d = MOVING;
            else            state_d = IDLE;
         end
         MOVING: begin
            if (step_s && (exit_l_s || exit_r_s)) state_d = SCORED;
            else                                  state_d = MOVING;
         end
         SCORED: begin
            if (frame_tick_s && (cnt_q == CNT_END)) state_d = IDLE;
            else                                    state_d = SCORED;
         end
         default: state_d = IDLE;
      endcase
   end

   // Position, velocity, counter and score-pulse updates.
   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      vx_d         = vx_q;
      vy_d         = vy_q;
      pend_d       = pend_q;
      cnt_d        = cnt_q;
      score_l_d    = 1'b0;
      score_r_d    = 1'b0;
      ball_state_d = (state_d == SCORED) ? 2'd1 : 2'd0;
      case (state_q)
         IDLE: begin
            x_d    = X_INIT;
            y_d    = Y_INIT;
            pend_d = 1'b0;
            cnt_d  = '0;
            if (bus.launch) begin
               vx_d = bus.vel_x;
               vy_d = bus.vel_y;
            end else begin
               vx_d = vx_q;
               vy_d = vy_q;
            end
         end
         MOVING: begin
            if (step_s) begin
               vx_d   = vx_eff_s;
               pend_d = 1'b0;
               if (ny_s <= 17'sd0) begin
                  y_d  = 16'd0;
                  vy_d = neg_sat(vy_q);
               end else if (ny_s >= Y_MAX) begin
                  y_d  = Y_MAX[15:0];
                  vy_d = neg_sat(vy_q);
               end else begin
                  y_d  = ny_s[15:0];
               end
               // x keeps its last on-screen value when the ball leaves.
               if (exit_r_s) begin
                  score_r_d = 1'b1;
               end else if (exit_l_s) begin
                  score_l_d = 1'b1;
               end else begin
                  x_d = nx_s[15:0];
               end
            end else begin
               pend_d = pend_q | bus.bounce_x;
            end
         end
         SCORED: begin
            pend_d = 1'b0;
            if (frame_tick_s) begin
               if (cnt_q == CNT_END) begin
                  cnt_d = '0;
                  x_d   = X_INIT;
                  y_d   = Y_INIT;
                  vx_d  = 8'd0;
                  vy_d  = 8'd0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            x_d    = X_INIT;
            y_d    = Y_INIT;
            vx_d   = 8'd0;
            vy_d   = 8'd0;
            pend_d = 1'b0;
            cnt_d  = '0;
         end
      endcase
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.ball_state = ball_state_q;
   assign bus.score_l    = score_l_q;
   assign bus.score_r    = score_r_q;

endmodule

// File: doc/ball_controller.md
BALL_CONTROLLER -- requirements
Module: ball_controller

Interface
REQ-001 Parameter SCREEN_W, default 1024, meaning visible width in pixels.
REQ-002 Parameter SCREEN_H, default 768, meaning visible height in lines.
REQ-003 Parameter BALL_SIZE, default 64, meaning sprite edge in pixels (64x64 colour map).
REQ-004 Parameter X0, default 480, meaning idle/respawn x.
REQ-005 Parameter Y0, default 352, meaning idle/respawn y.
REQ-006 Parameter HIDE_FRAMES, default 60, meaning frames hidden after a score.
REQ-007 clk  input  1  system clock; single clock domain.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 hcount  input  11  current pixel column from video timing.
REQ-010 vcount  input  10  current line from video timing.
REQ-011 launch  input  1  one-cycle pulse; start ball motion.
REQ-012 vel_x  input  8  signed launch x velocity, pixels/frame.
REQ-013 vel_y  input  8  signed launch y velocity, pixels/frame.
REQ-014 bounce_x  input  1  one-cycle pulse; paddle contact, reverse x.
REQ-015 pause  input  1  level; freeze motion while high.
REQ-016 x  output  16  registered ball left edge, drives sprite renderer.
REQ-017 y  output  16  registered ball top edge.
REQ-018 ball_state  output  2  0 visible, 1 hidden (scored), 2,3 unused.
REQ-019 score_l  output  1  one-cycle pulse; ball left via right edge.
REQ-020 score_r  output  1  one-cycle pulse; ball left via left edge.

Function
REQ-021 frame_tick SHALL be internal, high one cycle when hcount==0 and vcount==SCREEN_H; all motion updates SHALL occur only on frame_tick.
REQ-022 FSM states SHALL be IDLE, MOVING, SCORED; ball_state SHALL be 0 in IDLE/MOVING, 1 in SCORED.
REQ-023 IDLE: x=X0, y=Y0, motion stopped; launch SHALL latch vel_x/vel_y into vx/vy and enter MOVING next cycle.
REQ-024 launch outside IDLE SHALL be ignored; launch coincident with frame_tick in IDLE SHALL take effect, first position update on the following frame_tick.
REQ-025 MOVING, frame_tick, pause low: compute nx=x+sext(vx), ny=y+sext(vy) in 17-bit signed; x,y SHALL update one cycle after frame_tick.
REQ-026 ny<=0: y=0 and vy=-vy; ny>=SCREEN_H-BALL_SIZE: y=SCREEN_H-BALL_SIZE and vy=-vy; otherwise y=ny.
REQ-027 nx<0: score_r pulse, enter SCORED; nx>SCREEN_W-BALL_SIZE: score_l pulse, enter SCORED; x SHALL hold last in-range value.
REQ-028 Negation of -128 SHALL saturate to +127; vx, vy otherwise unchanged between events.
REQ-029 bounce_x in MOVING SHALL set a pending flag; at the next non-paused frame_tick vx SHALL be negated before nx is computed, then flag cleared; multiple pulses before the tick SHALL count once.
REQ-030 bounce_x outside MOVING SHALL be ignored and the pending flag cleared on leaving MOVING.
REQ-031 pause high on frame_tick SHALL leave x, y, vx, vy, pending flag unchanged.
REQ-032 SCORED: frame counter SHALL count frame_ticks; after HIDE_FRAMES ticks SHALL enter IDLE with x=X0, y=Y0, vx=vy=0.
REQ-033 score_l/score_r SHALL never both be high, at most one pulse per MOVING episode.

Reset
REQ-034 reset SHALL, in the cycle it is sampled, force IDLE, x=X0, y=Y0, vx=vy=0, ball_state=0, score pulses 0, counter 0, pending flag 0, regardless of state or pending tick.
REQ-035 reset SHALL take priority over launch, bounce_x and frame_tick in the same cycle.

Verification
REQ-036 Reset, launch vel_x=5 vel_y=-3, three frame_ticks -> x=495, y=343, ball_state=0.
REQ-037 MOVING y=2, vy=-5, frame_tick -> y=0, vy=+5; next tick -> y=5.
REQ-038 MOVING x=3, vx=-4, frame_tick -> score_r one cycle, ball_state=1, x=3; after 60 ticks -> IDLE, x=480, y=352, ball_state=0.
REQ-039 bounce_x twice then pause high over two ticks, pause low, tick with vx=+6, x=600 -> x=594, vx=-6.
REQ-040 vx=-128, bounce_x, tick -> vx=+127.
REQ-041 Reset asserted mid-SCORED at counter=30 -> IDLE, x=480, y=352, no score pulse, launch next cycle accepted.
